// File: rtl/rl_ram_arb_pkg.sv
// ----------------------------------------------------------------------------
// rl_ram_arb_pkg
// Shared constants and helpers for the rl_ram_1r1w_arb block.
//   MAX_NREQ    : largest supported requester count; the helper functions
//                 work on vectors of this width.
//   MAX_PTR_W   : width of a binary requester index at MAX_NREQ.
//   onehot2bin(): one-hot requester vector -> binary index.
//   rr_pick()   : round-robin pick. Rotates req so that ptr sits at bit 0,
//                 takes the lowest set bit, and rotates the result back.
// ----------------------------------------------------------------------------
package rl_ram_arb_pkg;

    localparam int MAX_NREQ  = 16;
    localparam int MAX_PTR_W = 4;

    function automatic logic [MAX_PTR_W-1:0] onehot2bin(input logic [MAX_NREQ-1:0] onehot);
        logic [MAX_PTR_W-1:0] bin;
        bin = '0;
        for (int i = 0; i < MAX_NREQ; i++) begin
            if (onehot[i]) begin
                bin = bin | MAX_PTR_W'(i);
            end
        end
        return bin;
    endfunction

    // Only the low nreq bits of req take part. The rotation wraps at nreq
    // rather than at MAX_NREQ, so non-power-of-2 counts rotate correctly.
    function automatic logic [MAX_NREQ-1:0] rr_pick(input logic [MAX_NREQ-1:0] req,
                                                    input int                  ptr,
                                                    input int                  nreq);
        logic [MAX_NREQ-1:0] rot;
        logic [MAX_NREQ-1:0] gnt;
        int                  first;
        int                  src;
        int                  dst;
        rot   = '0;
        gnt   = '0;
        first = -1;
        for (int i = 0; i < MAX_NREQ; i++) begin
            if (i < nreq) begin
                src = i + ptr;
                if (src >= nreq) begin
                    src = src - nreq;
                end
                rot[i] = req[src];
            end
        end
        // Walk downwards so the last hit is the lowest set bit.
        for (int i = MAX_NREQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                first = i;
            end
        end
        if (first >= 0) begin
            dst = first + ptr;
            if (dst >= nreq) begin
                dst = dst - nreq;
            end
            gnt[dst] = 1'b1;
        end
        return gnt;
    endfunction

endpackage

// File: rtl/rl_ram_1r1w.sv
// ----------------------------------------------------------------------------
// rl_ram_1r1w
// Simple dual-port RAM: one write port with byte enables and one read port
// with a registered read (latency 1). A read and a write to the same address
// in the same cycle return the newly written bytes (write-first bypass).
// Memory contents are never cleared; rst_ni clears only the read register.
// Ports:
//   clk_i    clock
//   rst_ni   synchronous active-low reset of the read data register
//   we_i     write enable; waddr_i/wdata_i/wbe_i are used when set
//   re_i     read enable; raddr_i is used when set
//   dout_o   read data, valid the cycle after re_i
// ----------------------------------------------------------------------------
module rl_ram_1r1w #(
    parameter int    ABITS      = 10,
    parameter int    DBITS      = 32,
    parameter string TECHNOLOGY = "GENERIC",
    parameter string INIT_FILE  = "",
    localparam int   BBITS      = (DBITS + 7) / 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             we_i,
    input  logic [ABITS-1:0] waddr_i,
    input  logic [DBITS-1:0] wdata_i,
    input  logic [BBITS-1:0] wbe_i,
    input  logic             re_i,
    input  logic [ABITS-1:0] raddr_i,
    output logic [DBITS-1:0] dout_o
);

    localparam int DEPTH = 1 << ABITS;
    localparam int PBITS = BBITS * 8;

    logic [BBITS-1:0][7:0] r_mem [DEPTH];
    logic [PBITS-1:0]      w_wdata_pad;
    logic [BBITS-1:0][7:0] w_rd_word;
    logic [BBITS-1:0][7:0] r_dout;
    logic [PBITS-1:0]      w_dout_flat;

    // Pad data up to whole bytes so every byte lane has 8 bits.
    assign w_wdata_pad = PBITS'(wdata_i);

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int b = 0; b < BBITS; b++) begin
                if (wbe_i[b]) begin
                    r_mem[waddr_i][b] <= w_wdata_pad[b*8 +: 8];
                end
            end
        end
    end

    // Write-first bypass, byte by byte: enabled bytes of a colliding write
    // replace the stored bytes in the word being read.
    always_comb begin
        w_rd_word = r_mem[raddr_i];
        for (int b = 0; b < BBITS; b++) begin
            if (we_i && wbe_i[b] && (waddr_i == raddr_i)) begin
                w_rd_word[b] = w_wdata_pad[b*8 +: 8];
            end
        end
    end

    generate
        if (TECHNOLOGY == "GENERIC" || INIT_FILE == "") begin : g_rd_generic
            always_ff @(posedge clk_i) begin
                if (!rst_ni) begin
                    r_dout <= '0;
                end else if (re_i) begin
                    r_dout <= w_rd_word;
                end
            end
        end else begin : g_rd_vendor
            // No vendor primitive is bundled here: use the same inferred
            // array and let the vendor flow attach the preload image.
            always_ff @(posedge clk_i) begin
                if (!rst_ni) begin
                    r_dout <= '0;
                end else if (re_i) begin
                    r_dout <= w_rd_word;
                end
            end
        end
    endgenerate

    assign w_dout_flat = r_dout;
    assign dout_o      = w_dout_flat[DBITS-1:0];

endmodule

// File: rtl/rl_ram_arb_rr.sv
// ----------------------------------------------------------------------------
// rl_ram_arb_rr
// Combinational request -> grant arbiter for one side (read or write) of the
// shared RAM. Grant is one-hot or zero and forced to zero during reset.
// Default build: round-robin. The search starts at an internal pointer; after
// a grant to k the pointer moves to (k+1) mod NREQ, otherwise it holds.
// With RL_RAM_ARB_FIXED_PRIO_EN defined: fixed priority, lowest index wins,
// and no pointer state exists.
// Ports:
//   clk_i   clock (pointer register)
//   rst_i   synchronous active-high reset; pointer -> 0, grant forced low
//   req_i   per-requester request vector
//   gnt_o   per-requester grant vector
// ----------------------------------------------------------------------------
module rl_ram_arb_rr
    import rl_ram_arb_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [NREQ-1:0] req_i,
    output logic [NREQ-1:0] gnt_o
);

    logic [MAX_NREQ-1:0] w_req_ext;
    logic [MAX_NREQ-1:0] w_gnt_ext;

    always_comb begin
        w_req_ext            = '0;
        w_req_ext[NREQ-1:0]  = req_i;
    end

`ifdef RL_RAM_ARB_FIXED_PRIO_EN
    // A search that always starts at 0 is plain lowest-index priority.
    assign w_gnt_ext = rr_pick(w_req_ext, 0, NREQ);

    logic w_unused_fixed;
    assign w_unused_fixed = ^{clk_i, w_gnt_ext};
`else
    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_ptr_next;
    int               w_k;

    assign w_gnt_ext = rr_pick(w_req_ext, int'(r_ptr), NREQ);

    // Explicit wrap at NREQ-1 so non-power-of-2 counts never reach an
    // out-of-range pointer value.
    always_comb begin
        w_ptr_next = r_ptr;
        w_k        = int'(onehot2bin(w_gnt_ext));
        if (|w_gnt_ext) begin
            w_ptr_next = (w_k == NREQ - 1) ? '0 : PTR_W'(w_k + 1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ptr <= '0;
        end else begin
            r_ptr <= w_ptr_next;
        end
    end
`endif

    assign gnt_o = rst_i ? '0 : w_gnt_ext[NREQ-1:0];

endmodule

// File: rtl/rl_ram_1r1w_arb.sv
// ----------------------------------------------------------------------------
// rl_ram_1r1w_arb
// Shares one 1R1W RAM between NREQ requesters. Write and read sides each have
// their own arbiter, so one write and one read can complete in the same cycle.
// A transfer happens in any cycle with req && gnt; read data returns exactly
// one cycle after the grant, flagged by rvalid_o[owner].
// Build option: RL_RAM_ARB_FIXED_PRIO_EN selects fixed priority (lowest index
// wins) on both sides instead of round-robin.
// Ports:
//   clk_i     clock
//   rst_i     synchronous active-high reset
//   wreq_i    write requests          wgnt_o  write grants (one-hot/zero)
//   waddr_i   packed write addresses  wdata_i packed write data
//   wbe_i     packed byte enables
//   rreq_i    read requests           rgnt_o  read grants (one-hot/zero)
//   raddr_i   packed read addresses
//   rvalid_o  read response owner (one-hot/zero)
//   rdata_o   shared read data, meaningful only when rvalid_o != 0
// ----------------------------------------------------------------------------
module rl_ram_1r1w_arb
    import rl_ram_arb_pkg::*;
#(
    parameter int    NREQ       = 4,
    parameter int    ABITS      = 10,
    parameter int    DBITS      = 32,
    parameter string TECHNOLOGY = "GENERIC",
    parameter string INIT_FILE  = "",
    localparam int   BBITS      = (DBITS + 7) / 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NREQ-1:0]       wreq_i,
    input  logic [NREQ*ABITS-1:0] waddr_i,
    input  logic [NREQ*DBITS-1:0] wdata_i,
    input  logic [NREQ*BBITS-1:0] wbe_i,
    output logic [NREQ-1:0]       wgnt_o,
    input  logic [NREQ-1:0]       rreq_i,
    input  logic [NREQ*ABITS-1:0] raddr_i,
    output logic [NREQ-1:0]       rgnt_o,
    output logic [NREQ-1:0]       rvalid_o,
    output logic [DBITS-1:0]      rdata_o
);

    logic [NREQ-1:0]  w_wgnt;
    logic [NREQ-1:0]  w_rgnt;
    logic [NREQ-1:0]  r_rvalid;

    logic [ABITS-1:0] w_waddr;
    logic [DBITS-1:0] w_wdata;
    logic [BBITS-1:0] w_wbe;
    logic [ABITS-1:0] w_raddr;
    logic [DBITS-1:0] w_ram_dout;

    logic [ABITS-1:0] w_waddr_term [NREQ];
    logic [DBITS-1:0] w_wdata_term [NREQ];
    logic [BBITS-1:0] w_wbe_term   [NREQ];
    logic [ABITS-1:0] w_raddr_term [NREQ];

    rl_ram_arb_rr #(.NREQ(NREQ)) u_warb (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .req_i (wreq_i),
        .gnt_o (w_wgnt)
    );

    rl_ram_arb_rr #(.NREQ(NREQ)) u_rarb (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .req_i (rreq_i),
        .gnt_o (w_rgnt)
    );

    // Grants are one-hot, so an AND-OR mux is enough to select the winner.
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_req
            assign w_waddr_term[gi] = waddr_i[gi*ABITS +: ABITS] & {ABITS{w_wgnt[gi]}};
            assign w_wdata_term[gi] = wdata_i[gi*DBITS +: DBITS] & {DBITS{w_wgnt[gi]}};
            assign w_wbe_term[gi]   = wbe_i[gi*BBITS +: BBITS]   & {BBITS{w_wgnt[gi]}};
            assign w_raddr_term[gi] = raddr_i[gi*ABITS +: ABITS] & {ABITS{w_rgnt[gi]}};
        end
    endgenerate

    always_comb begin
        w_waddr = '0;
        w_wdata = '0;
        w_wbe   = '0;
        w_raddr = '0;
        for (int n = 0; n < NREQ; n++) begin
            w_waddr = w_waddr | w_waddr_term[n];
            w_wdata = w_wdata | w_wdata_term[n];
            w_wbe   = w_wbe   | w_wbe_term[n];
            w_raddr = w_raddr | w_raddr_term[n];
        end
    end

    rl_ram_1r1w #(
        .ABITS      (ABITS),
        .DBITS      (DBITS),
        .TECHNOLOGY (TECHNOLOGY),
        .INIT_FILE  (INIT_FILE)
    ) u_ram (
        .clk_i   (clk_i),
        .rst_ni  (~rst_i),
        .we_i    (|w_wgnt),
        .waddr_i (w_waddr),
        .wdata_i (w_wdata),
        .wbe_i   (w_wbe),
        .re_i    (|w_rgnt),
        .raddr_i (w_raddr),
        .dout_o  (w_ram_dout)
    );

    // The read grant travels one cycle alongside the RAM read.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rvalid <= '0;
        end else begin
            r_rvalid <= w_rgnt;
        end
    end

    // Masking with rst_i drops the response of a read granted in the cycle
    // just before reset asserts.
    assign rvalid_o = r_rvalid & ~{NREQ{rst_i}};
    assign rdata_o  = w_ram_dout;
    assign wgnt_o   = w_wgnt;
    assign rgnt_o   = w_rgnt;

endmodule
